dummy_rtl_dma_stream: RTL and testbench

- Parametrised DMA test accelerator, the successor to the fixed 64-bit stub accelerator.
- Reads conf_info_size words from memory in bursts of up to BURST_MAX words and applies a per-word transform selected by conf_info_mode.
- Writes the results back to memory immediately after the input region, then signals completion.
- Sits in the accelerator tile behind the standard ESP DMA ctrl/chnl valid-ready interfaces; used to bring up and stress the DMA path.

---
 rtl/dummy_rtl_dma_stream_pkg.sv | 50 +++++
 rtl/dummy_rtl_dma_buf.sv | 36 +++
 rtl/dummy_rtl_dma_stream.sv | 239 +++++++++++++++++++++++
 tb/tb_dummy_rtl_dma_stream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dummy_rtl_dma_stream_pkg.sv
// Shared types, mode encodings and word helpers for the DMA stream accelerator.
package dummy_rtl_dma_stream_pkg;

  localparam int unsigned WORD_MAX_W = 64;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    WR_DATA,
    DONE
  } state_e;

  localparam logic [1:0] MODE_COPY     = 2'd0;
  localparam logic [1:0] MODE_INVERT   = 2'd1;
  localparam logic [1:0] MODE_INC      = 2'd2;
  localparam logic [1:0] MODE_COPY_ALT = 2'd3;

  // Payload of a DMA ctrl request (read or write side).
  typedef struct packed {
    logic [CNT_W-1:0] index;
    logic [CNT_W-1:0] length;
    logic [2:0]       size;
  } dma_ctrl_t;

  function automatic logic [2:0] size_code(input int unsigned data_w);
    return (data_w == 32) ? 3'd2 : 3'd3;
  endfunction

  // Evaluated at full width; callers truncate, so increment wraps at their word width.
  function automatic logic [WORD_MAX_W-1:0] transform(input logic [1:0]            mode,
                                                      input logic [WORD_MAX_W-1:0] word);
    logic [WORD_MAX_W-1:0] res;
    res = word;
    case (mode)
      MODE_INVERT: res = ~word;
      MODE_INC:    res = word + WORD_MAX_W'(1);
      default:     res = word;
    endcase
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] burst_len(input logic [CNT_W-1:0] remaining,
                                                 input logic [CNT_W-1:0] burst_max);
    return (remaining > burst_max) ? burst_max : remaining;
  endfunction

endpackage

// File: rtl/dummy_rtl_dma_buf.sv
// Burst staging buffer: one write port, one registered read port.
module dummy_rtl_dma_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dummy_rtl_dma_stream.sv
// DMA test accelerator: burst-reads words, transforms them, writes them back after the input region.
module dummy_rtl_dma_stream
  import dummy_rtl_dma_stream_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       conf_info_size,
  input  logic [31:0]       conf_info_mode,
  input  logic              conf_done,
  output logic              dma_read_ctrl_valid,
  input  logic              dma_read_ctrl_ready,
  output logic [31:0]       dma_read_ctrl_data_index,
  output logic [31:0]       dma_read_ctrl_data_length,
  output logic [2:0]        dma_read_ctrl_data_size,
  input  logic              dma_read_chnl_valid,
  output logic              dma_read_chnl_ready,
  input  logic [DATA_W-1:0] dma_read_chnl_data,
  output logic              dma_write_ctrl_valid,
  input  logic              dma_write_ctrl_ready,
  output logic [31:0]       dma_write_ctrl_data_index,
  output logic [31:0]       dma_write_ctrl_data_length,
  output logic [2:0]        dma_write_ctrl_data_size,
  output logic              dma_write_chnl_valid,
  input  logic              dma_write_chnl_ready,
  output logic [DATA_W-1:0] dma_write_chnl_data,
  output logic              acc_done,
  output logic [31:0]       debug
);

  localparam int unsigned     AW          = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [2:0]      SIZE_CODE   = size_code(DATA_W);
  localparam logic [CNT_W-1:0] BURST_MAX_W = CNT_W'(BURST_MAX);
  localparam dma_ctrl_t       CTRL_RST    = '{index: '0, length: '0, size: SIZE_CODE};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] size_q, size_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] processed_q, processed_d;
  logic [AW-1:0]    beat_q, beat_d;
  logic [AW-1:0]    wbeat_q, wbeat_d;
  logic [CNT_W-1:0] debug_q, debug_d;
  logic             acc_done_q, acc_done_d;
  logic             rd_ctrl_valid_q, rd_ctrl_valid_d;
  logic             rd_chnl_ready_q, rd_chnl_ready_d;
  logic             wr_ctrl_valid_q, wr_ctrl_valid_d;
  logic             wr_chnl_valid_q, wr_chnl_valid_d;
  dma_ctrl_t        rd_ctrl_q, rd_ctrl_d;
  dma_ctrl_t        wr_ctrl_q, wr_ctrl_d;

  logic              buf_we_c;
  logic [AW-1:0]     buf_waddr_c;
  logic [DATA_W-1:0] buf_wdata_c;
  logic              buf_re_c;
  logic [AW-1:0]     buf_raddr_c;
  logic [DATA_W-1:0] buf_rdata_c;

  logic             rd_ctrl_hs_c, rd_chnl_hs_c, wr_ctrl_hs_c, wr_chnl_hs_c;
  logic             last_rd_beat_c, last_wr_beat_c;
  logic [CNT_W-1:0] next_proc_c, next_len_c, first_len_c;
  logic             unused_mode_c;

  assign rd_ctrl_hs_c   = rd_ctrl_valid_q & dma_read_ctrl_ready;
  assign rd_chnl_hs_c   = rd_chnl_ready_q & dma_read_chnl_valid;
  assign wr_ctrl_hs_c   = wr_ctrl_valid_q & dma_write_ctrl_ready;
  assign wr_chnl_hs_c   = wr_chnl_valid_q & dma_write_chnl_ready;
  // The current burst length lives in the read request payload and is reused on the write side.
  assign last_rd_beat_c = (beat_q == AW'(rd_ctrl_q.length - CNT_W'(1)));
  assign last_wr_beat_c = (wbeat_q == AW'(rd_ctrl_q.length - CNT_W'(1)));
  assign next_proc_c    = processed_q + rd_ctrl_q.length;
  assign next_len_c     = burst_len(size_q - next_proc_c, BURST_MAX_W);
  assign first_len_c    = burst_len(conf_info_size, BURST_MAX_W);
  assign unused_mode_c  = ^conf_info_mode[31:2];

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    size_d          = size_q;
    mode_d          = mode_q;
    processed_d     = processed_q;
    beat_d          = beat_q;
    wbeat_d         = wbeat_q;
    debug_d         = debug_q;
    acc_done_d      = 1'b0;
    rd_ctrl_valid_d = rd_ctrl_valid_q;
    rd_chnl_ready_d = rd_chnl_ready_q;
    wr_ctrl_valid_d = wr_ctrl_valid_q;
    wr_chnl_valid_d = wr_chnl_valid_q;
    rd_ctrl_d       = rd_ctrl_q;
    wr_ctrl_d       = wr_ctrl_q;
    buf_we_c        = 1'b0;
    buf_waddr_c     = beat_q;
    buf_wdata_c     = DATA_W'(transform(mode_q, WORD_MAX_W'(dma_read_chnl_data)));
    buf_re_c        = 1'b0;
    buf_raddr_c     = '0;

    case (state_q)
      IDLE: begin
        if (conf_done) begin
          size_d      = conf_info_size;
          mode_d      = conf_info_mode[1:0];
          processed_d = '0;
          if (conf_info_size != '0) begin
            state_d          = RD_REQ;
            rd_ctrl_valid_d  = 1'b1;
            rd_ctrl_d.index  = '0;
            rd_ctrl_d.length = first_len_c;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_REQ: begin
        if (rd_ctrl_hs_c) begin
          rd_ctrl_valid_d = 1'b0;
          rd_chnl_ready_d = 1'b1;
          beat_d          = '0;
          state_d         = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_chnl_hs_c) begin
          buf_we_c = 1'b1;
          beat_d   = beat_q + AW'(1);
          if (last_rd_beat_c) begin
            rd_chnl_ready_d  = 1'b0;
            wr_ctrl_valid_d  = 1'b1;
            wr_ctrl_d.index  = size_q + processed_q;
            wr_ctrl_d.length = rd_ctrl_q.length;
            state_d          = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        // Prefetch word 0 so it is on the bus together with the rising write valid.
        if (wr_ctrl_hs_c) begin
          wr_ctrl_valid_d = 1'b0;
          wr_chnl_valid_d = 1'b1;
          wbeat_d         = '0;
          buf_re_c        = 1'b1;
          buf_raddr_c     = '0;
          state_d         = WR_DATA;
        end
      end
      WR_DATA: begin
        if (wr_chnl_hs_c) begin
          debug_d = debug_q + CNT_W'(1);
          if (last_wr_beat_c) begin
            wr_chnl_valid_d = 1'b0;
            processed_d     = next_proc_c;
            if (next_proc_c == size_q) begin
              state_d = DONE;
            end else begin
              state_d          = RD_REQ;
              rd_ctrl_valid_d  = 1'b1;
              rd_ctrl_d.index  = next_proc_c;
              rd_ctrl_d.length = next_len_c;
            end
          end else begin
            wbeat_d     = wbeat_q + AW'(1);
            buf_re_c    = 1'b1;
            buf_raddr_c = wbeat_q + AW'(1);
          end
        end
      end
      DONE: begin
        acc_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      size_q          <= '0;
      mode_q          <= MODE_COPY;
      processed_q     <= '0;
      beat_q          <= '0;
      wbeat_q         <= '0;
      debug_q         <= '0;
      acc_done_q      <= 1'b0;
      rd_ctrl_valid_q <= 1'b0;
      rd_chnl_ready_q <= 1'b0;
      wr_ctrl_valid_q <= 1'b0;
      wr_chnl_valid_q <= 1'b0;
      rd_ctrl_q       <= CTRL_RST;
      wr_ctrl_q       <= CTRL_RST;
    end else begin
      state_q         <= state_d;
      size_q          <= size_d;
      mode_q          <= mode_d;
      processed_q     <= processed_d;
      beat_q          <= beat_d;
      wbeat_q         <= wbeat_d;
      debug_q         <= debug_d;
      acc_done_q      <= acc_done_d;
      rd_ctrl_valid_q <= rd_ctrl_valid_d;
      rd_chnl_ready_q <= rd_chnl_ready_d;
      wr_ctrl_valid_q <= wr_ctrl_valid_d;
      wr_chnl_valid_q <= wr_chnl_valid_d;
      rd_ctrl_q       <= rd_ctrl_d;
      wr_ctrl_q       <= wr_ctrl_d;
    end
  end

  dummy_rtl_dma_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BURST_MAX),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (buf_we_c),
    .waddr_i (buf_waddr_c),
    .wdata_i (buf_wdata_c),
    .re_i    (buf_re_c),
    .raddr_i (buf_raddr_c),
    .rdata_o (buf_rdata_c)
  );

  assign dma_read_ctrl_valid        = rd_ctrl_valid_q;
  assign dma_read_ctrl_data_index   = rd_ctrl_q.index;
  assign dma_read_ctrl_data_length  = rd_ctrl_q.length;
  assign dma_read_ctrl_data_size    = rd_ctrl_q.size;
  assign dma_read_chnl_ready        = rd_chnl_ready_q;
  assign dma_write_ctrl_valid       = wr_ctrl_valid_q;
  assign dma_write_ctrl_data_index  = wr_ctrl_q.index;
  assign dma_write_ctrl_data_length = wr_ctrl_q.length;
  assign dma_write_ctrl_data_size   = wr_ctrl_q.size;
  assign dma_write_chnl_valid       = wr_chnl_valid_q;
  assign dma_write_chnl_data        = buf_rdata_c;
  assign acc_done                   = acc_done_q;
  assign debug                      = debug_q;

endmodule

// File: tb/tb_dummy_rtl_dma_stream.sv
// Directed bench: acts as memory/DMA engine and checks requests, data, timing and protocol.
module tb_dummy_rtl_dma_stream;

  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       conf_info_size;
  logic [31:0]       conf_info_mode;
  logic              conf_done;
  logic              dma_read_ctrl_valid;
  logic              dma_read_ctrl_ready;
  logic [31:0]       dma_read_ctrl_data_index;
  logic [31:0]       dma_read_ctrl_data_length;
  logic [2:0]        dma_read_ctrl_data_size;
  logic              dma_read_chnl_valid;
  logic              dma_read_chnl_ready;
  logic [DATA_W-1:0] dma_read_chnl_data;
  logic              dma_write_ctrl_valid;
  logic              dma_write_ctrl_ready;
  logic [31:0]       dma_write_ctrl_data_index;
  logic [31:0]       dma_write_ctrl_data_length;
  logic [2:0]        dma_write_ctrl_data_size;
  logic              dma_write_chnl_valid;
  logic              dma_write_chnl_ready;
  logic [DATA_W-1:0] dma_write_chnl_data;
  logic              acc_done;
  logic [31:0]       debug;

  int checks   = 0;
  int failures = 0;
  logic [63:0] mem_in [64];

  always #5 clk = ~clk;

  dummy_rtl_dma_stream #(.DATA_W(64), .BURST_MAX(16)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .conf_info_size             (conf_info_size),
    .conf_info_mode             (conf_info_mode),
    .conf_done                  (conf_done),
    .dma_read_ctrl_valid        (dma_read_ctrl_valid),
    .dma_read_ctrl_ready        (dma_read_ctrl_ready),
    .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
    .dma_read_chnl_valid        (dma_read_chnl_valid),
    .dma_read_chnl_ready        (dma_read_chnl_ready),
    .dma_read_chnl_data         (dma_read_chnl_data),
    .dma_write_ctrl_valid       (dma_write_ctrl_valid),
    .dma_write_ctrl_ready       (dma_write_ctrl_ready),
    .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
    .dma_write_chnl_valid       (dma_write_chnl_valid),
    .dma_write_chnl_ready       (dma_write_chnl_ready),
    .dma_write_chnl_data        (dma_write_chnl_data),
    .acc_done                   (acc_done),
    .debug                      (debug)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] xf(input logic [1:0] m, input logic [63:0] w);
    case (m)
      2'd1:    return ~w;
      2'd2:    return w + 64'd1;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] min16(input logic [31:0] r);
    return (r > 32'd16) ? 32'd16 : r;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge. Starts a run and services all four channels until done (or abort).
  task automatic run(input logic [31:0] size, input logic [1:0] mode, input bit rnd,
                     input int abort_after, output logic [63:0] last_wdata,
                     output int rd_bursts, output int wr_bursts);
    int cyc, last_wr_cyc, done_cyc;
    bit fin, rcr, rcv, wcr, wchr;
    bit p_rc_v, p_rc_hs, p_wc_v, p_wc_hs, p_wd_v, p_wd_hs;
    logic [31:0] proc_r, proc_w, rd_next, wr_cnt, p_rc_idx, p_wc_idx;
    logic [63:0] p_wd;
    cyc = 0; last_wr_cyc = 0; done_cyc = -1; fin = 1'b0;
    p_rc_v = 0; p_rc_hs = 0; p_wc_v = 0; p_wc_hs = 0; p_wd_v = 0; p_wd_hs = 0;
    proc_r = 0; proc_w = 0; rd_next = 0; wr_cnt = 0; p_rc_idx = 0; p_wc_idx = 0; p_wd = 0;
    last_wdata = '0; rd_bursts = 0; wr_bursts = 0;
    conf_info_size = size;
    conf_info_mode = {30'd0, mode};
    conf_done      = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      conf_done = 1'b0;
      if (p_rc_v && !p_rc_hs) begin
        check("rd_ctrl_valid_hold", 64'(dma_read_ctrl_valid), 64'd1);
        check("rd_ctrl_index_stable", 64'(dma_read_ctrl_data_index), 64'(p_rc_idx));
      end
      if (p_wc_v && !p_wc_hs) begin
        check("wr_ctrl_valid_hold", 64'(dma_write_ctrl_valid), 64'd1);
        check("wr_ctrl_index_stable", 64'(dma_write_ctrl_data_index), 64'(p_wc_idx));
      end
      if (p_wd_v && !p_wd_hs) begin
        check("wr_chnl_valid_hold", 64'(dma_write_chnl_valid), 64'd1);
        check("wr_chnl_data_stable", dma_write_chnl_data, p_wd);
      end
      check("channel_overlap", ($countones({dma_read_ctrl_valid, dma_read_chnl_ready,
            dma_write_ctrl_valid, dma_write_chnl_valid}) > 1) ? 64'd1 : 64'd0, 64'd0);
      if (done_cyc >= 0) begin
        check("post_done_idle", 64'({dma_read_ctrl_valid, dma_read_chnl_ready,
              dma_write_ctrl_valid, dma_write_chnl_valid, acc_done}), 64'd0);
        if (cyc >= done_cyc + 2) fin = 1'b1;
      end else if (acc_done) begin
        done_cyc = cyc;
        check("done_latency", 64'(cyc - ((size == 0) ? 0 : last_wr_cyc)), 64'd2);
      end
      rcr  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rcv  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wcr  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wchr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dma_read_ctrl_ready  = rcr;
      dma_read_chnl_valid  = rcv;
      dma_read_chnl_data   = mem_in[rd_next[5:0]];
      dma_write_ctrl_ready = wcr;
      dma_write_chnl_ready = wchr;
      p_rc_v = dma_read_ctrl_valid; p_rc_hs = dma_read_ctrl_valid && rcr;
      p_rc_idx = dma_read_ctrl_data_index;
      if (p_rc_hs) begin
        check("rd_index", 64'(dma_read_ctrl_data_index), 64'(proc_r));
        check("rd_length", 64'(dma_read_ctrl_data_length), 64'(min16(size - proc_r)));
        check("rd_size", 64'(dma_read_ctrl_data_size), 64'd3);
        proc_r = proc_r + min16(size - proc_r);
        rd_bursts++;
      end
      if (dma_read_chnl_ready && rcv) rd_next++;
      p_wc_v = dma_write_ctrl_valid; p_wc_hs = dma_write_ctrl_valid && wcr;
      p_wc_idx = dma_write_ctrl_data_index;
      if (p_wc_hs) begin
        check("wr_index", 64'(dma_write_ctrl_data_index), 64'(size + proc_w));
        check("wr_length", 64'(dma_write_ctrl_data_length), 64'(min16(size - proc_w)));
        check("wr_size", 64'(dma_write_ctrl_data_size), 64'd3);
        proc_w = proc_w + min16(size - proc_w);
        wr_bursts++;
      end
      p_wd_v = dma_write_chnl_valid; p_wd_hs = dma_write_chnl_valid && wchr;
      p_wd = dma_write_chnl_data;
      if (p_wd_hs) begin
        check("wr_data", dma_write_chnl_data, xf(mode, mem_in[wr_cnt[5:0]]));
        last_wdata  = dma_write_chnl_data;
        last_wr_cyc = cyc;
        wr_cnt++;
        if (abort_after > 0 && wr_cnt >= 32'(abort_after)) begin
          rst = 1'b1;
          fin = 1'b1;
        end
      end
      if (cyc >= 4000) begin
        check("run_timeout", 64'd1, 64'd0);
        fin = 1'b1;
      end
    end
    if (abort_after == 0) begin
      check("done_seen", (done_cyc >= 0) ? 64'd1 : 64'd0, 64'd1);
      check("words_read", 64'(rd_next), 64'(size));
      check("words_written", 64'(wr_cnt), 64'(size));
      check("debug_count", 64'(debug), 64'(size));
    end
  endtask

  initial begin
    logic [63:0] lw;
    int rb, wb;
    rst = 1'b1; conf_done = 1'b0; conf_info_size = '0; conf_info_mode = '0;
    dma_read_ctrl_ready = 1'b0; dma_read_chnl_valid = 1'b0; dma_read_chnl_data = '0;
    dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_ctrl_valid", 64'(dma_read_ctrl_valid), 64'd0);
    check("rst_rd_chnl_ready", 64'(dma_read_chnl_ready), 64'd0);
    check("rst_wr_ctrl_valid", 64'(dma_write_ctrl_valid), 64'd0);
    check("rst_wr_chnl_valid", 64'(dma_write_chnl_valid), 64'd0);
    check("rst_acc_done", 64'(acc_done), 64'd0);
    check("rst_debug", 64'(debug), 64'd0);
    rst = 1'b0;

    // size=4 copy: one burst each way, data 0..3
    for (int i = 0; i < 64; i++) mem_in[i] = 64'(i);
    run(32'd4, 2'd0, 1'b0, 0, lw, rb, wb);
    check("s4_rd_bursts", 64'(rb), 64'd1);
    check("s4_wr_bursts", 64'(wb), 64'd1);
    check("s4_last_word", lw, 64'd3);

    // size=37: bursts of 16, 16, 5
    reset_dut();
    for (int i = 0; i < 64; i++) mem_in[i] = {32'hA5A5_0000 | 32'(i), ~32'(i)};
    run(32'd37, 2'd3, 1'b0, 0, lw, rb, wb);
    check("s37_rd_bursts", 64'(rb), 64'd3);
    check("s37_wr_bursts", 64'(wb), 64'd3);
    check("s37_last_word", lw, 64'hA5A5_0024_FFFF_FFDB);

    // invert
    reset_dut();
    mem_in[0] = 64'h0000_0000_FFFF_FFFF;
    run(32'd1, 2'd1, 1'b0, 0, lw, rb, wb);
    check("invert_word", lw, 64'hFFFF_FFFF_0000_0000);

    // increment wraps
    reset_dut();
    mem_in[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run(32'd1, 2'd2, 1'b0, 0, lw, rb, wb);
    check("inc_wrap_word", lw, 64'd0);

    // size=0: no DMA traffic, done two cycles after conf_done
    reset_dut();
    run(32'd0, 2'd0, 1'b0, 0, lw, rb, wb);
    check("s0_rd_bursts", 64'(rb), 64'd0);
    check("s0_wr_bursts", 64'(wb), 64'd0);

    // random handshakes
    reset_dut();
    for (int i = 0; i < 64; i++) mem_in[i] = {$urandom, $urandom};
    run(32'd20, 2'd2, 1'b1, 0, lw, rb, wb);
    check("rnd_rd_bursts", 64'(rb), 64'd2);

    // reset in the middle of write streaming, then a clean run
    reset_dut();
    for (int i = 0; i < 64; i++) mem_in[i] = 64'(i) * 64'h0101_0101;
    run(32'd32, 2'd0, 1'b0, 5, lw, rb, wb);
    @(negedge clk);
    check("abort_valids", 64'({dma_read_ctrl_valid, dma_read_chnl_ready,
          dma_write_ctrl_valid, dma_write_chnl_valid}), 64'd0);
    check("abort_debug", 64'(debug), 64'd0);
    rst = 1'b0;
    run(32'd2, 2'd0, 1'b0, 0, lw, rb, wb);
    check("post_abort_last", lw, 64'h0101_0101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
